// File: rtl/exit_token_validator.sv
// rtl/exit_token_validator.sv - exit-side token table, lookup FSM, gate and lockout timers
// Optional fee tracking via PARK_FEE_EN (per-slot elapsed counters; fee held 0 when undefined).
module exit_token_validator #(
    parameter int SLOTS        = 8,
    parameter int TOKEN_W      = 5,
    parameter int FEE_W        = 8,
    parameter int GATE_TICKS   = 3,
    parameter int MAX_ATTEMPTS = 3,
    parameter int LOCK_TICKS   = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       issue_valid,
    input  logic [TOKEN_W-1:0]         issue_token,
    output logic                       issue_ready,
    input  logic                       exit_sensor,
    input  logic                       exit_btn,
    input  logic [TOKEN_W-1:0]         token_input,
    output logic                       busy,
    output logic                       result_valid,
    output logic                       result_ok,
    output logic [FEE_W-1:0]           fee,
    output logic                       gate_open,
    output logic                       lockout,
    output logic [$clog2(SLOTS+1)-1:0] occupancy
);
    localparam int IW = $clog2(SLOTS);
    localparam int OW = $clog2(SLOTS+1);
    localparam int AW = $clog2(MAX_ATTEMPTS+1);
    localparam int TW = $clog2(GATE_TICKS+LOCK_TICKS+1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_OPEN = 3'd2;
    localparam logic [2:0] S_DENY = 3'd3;
    localparam logic [2:0] S_LOCK = 3'd4;

    logic [SLOTS-1:0]   r_valid;
    logic [TOKEN_W-1:0] r_tok [SLOTS];
    logic [2:0]         r_state;
    logic [IW-1:0]      r_idx;
    logic [TOKEN_W-1:0] r_cap;
    logic               r_btn_prev;
    logic [AW-1:0]      r_attempts;
    logic [TW-1:0]      r_timer;
    logic               r_result_valid;
    logic               r_result_ok;
    logic [FEE_W-1:0]   r_fee;

    logic [OW-1:0]      w_occ;
    logic               w_dup;
    logic [IW-1:0]      w_free_idx;
    logic               w_accept;
    logic               w_hit;
    logic               w_last;
    logic [FEE_W-1:0]   w_fee_hit;

    always_comb begin
        w_occ      = '0;
        w_dup      = 1'b0;
        w_free_idx = '0;
        for (int i = SLOTS-1; i >= 0; i--) begin
            w_occ = w_occ + OW'(r_valid[i]);
            if (r_valid[i] && r_tok[i] == issue_token) w_dup = 1'b1;
            if (!r_valid[i]) w_free_idx = IW'(i);
        end
    end

    assign issue_ready = (w_occ != OW'(SLOTS));
    // A duplicate is accepted on the handshake but never occupies a second slot.
    assign w_accept    = issue_valid && issue_ready && !w_dup;
    assign w_hit       = (r_state == S_SCAN) && r_valid[r_idx] && (r_tok[r_idx] == r_cap);
    assign w_last      = (r_idx == IW'(SLOTS-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (w_accept) begin
                r_valid[w_free_idx] <= 1'b1;
                r_tok[w_free_idx]   <= issue_token;
            end
            if (w_hit) r_valid[r_idx] <= 1'b0;
        end
    end

`ifdef PARK_FEE_EN
    logic [FEE_W-1:0] r_elapsed [SLOTS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < SLOTS; i++) begin
            if (reset) begin
                r_elapsed[i] <= '0;
            end else if (w_accept && w_free_idx == IW'(i)) begin
                r_elapsed[i] <= '0;
            end else if (tick && r_valid[i] && r_elapsed[i] != '1) begin
                r_elapsed[i] <= r_elapsed[i] + 1'b1;
            end
        end
    end

    assign w_fee_hit = (r_elapsed[r_idx] == '0) ? FEE_W'(1) : r_elapsed[r_idx];
`else
    assign w_fee_hit = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_cap          <= '0;
            r_btn_prev     <= 1'b0;
            r_attempts     <= '0;
            r_timer        <= '0;
            r_result_valid <= 1'b0;
            r_result_ok    <= 1'b0;
            r_fee          <= '0;
        end else begin
            r_btn_prev     <= exit_btn;
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (exit_btn && !r_btn_prev && exit_sensor) begin
                        r_cap   <= token_input;
                        r_idx   <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_fee          <= w_fee_hit;
                        r_result_ok    <= 1'b1;
                        r_result_valid <= 1'b1;
                        r_attempts     <= '0;
                        r_timer        <= '0;
                        r_state        <= S_OPEN;
                    end else if (w_last) begin
                        r_result_ok    <= 1'b0;
                        r_result_valid <= 1'b1;
                        r_timer        <= '0;
                        if (r_attempts == AW'(MAX_ATTEMPTS-1)) begin
                            r_attempts <= '0;
                            r_state    <= S_LOCK;
                        end else begin
                            r_attempts <= r_attempts + 1'b1;
                            r_state    <= S_DENY;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_OPEN: begin
                    if (tick) begin
                        if (r_timer == TW'(GATE_TICKS-1)) begin
                            r_timer <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                S_DENY: r_state <= S_IDLE;
                S_LOCK: begin
                    if (tick) begin
                        if (r_timer == TW'(LOCK_TICKS-1)) begin
                            r_timer <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign result_valid = r_result_valid;
    assign result_ok    = r_result_ok;
    assign fee          = r_fee;
    assign gate_open    = (r_state == S_OPEN);
    assign lockout      = (r_state == S_LOCK);
    assign occupancy    = w_occ;
endmodule

// File: tb/tb_exit_token_validator.sv
// tb/tb_exit_token_validator.sv - directed self-checking bench for exit_token_validator
module tb_exit_token_validator;
    logic       clk = 1'b0;
    logic       reset, tick, issue_valid, issue_ready, exit_sensor, exit_btn;
    logic [4:0] issue_token, token_input;
    logic       busy, result_valid, result_ok, gate_open, lockout;
    logic [7:0] fee;
    logic [3:0] occupancy;

    int n_pass  = 0;
    int n_total = 0;

    exit_token_validator dut (
        .clk(clk), .reset(reset), .tick(tick),
        .issue_valid(issue_valid), .issue_token(issue_token), .issue_ready(issue_ready),
        .exit_sensor(exit_sensor), .exit_btn(exit_btn), .token_input(token_input),
        .busy(busy), .result_valid(result_valid), .result_ok(result_ok), .fee(fee),
        .gate_open(gate_open), .lockout(lockout), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_tick(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic do_issue(input logic [4:0] tok);
        issue_valid = 1'b1;
        issue_token = tok;
        step();
        issue_valid = 1'b0;
    endtask

    // Edge on exit_btn, then count cycles until result_valid is seen.
    task automatic press(input string tag, input logic [4:0] tok, input int exp_n,
                         input logic exp_ok, input logic [7:0] exp_fee, input bit chk_fee);
        int n;
        n           = 0;
        token_input = tok;
        exit_sensor = 1'b1;
        exit_btn    = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 1) exit_btn = 1'b0;
            if (result_valid) begin
                n = k;
                break;
            end
        end
        chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_ok"}, result_ok, exp_ok);
        if (chk_fee) chk({tag, "_fee"}, fee, exp_fee);
    endtask

    initial begin
        bit seen_busy, seen_rv;
        reset = 1'b1; tick = 1'b0; issue_valid = 1'b0; issue_token = '0;
        exit_sensor = 1'b0; exit_btn = 1'b0; token_input = '0;
        step(2);
        reset = 1'b0;
        step();
        chk("rst_occ", occupancy, 0);
        chk("rst_ready", issue_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_ok", result_ok, 0);
        chk("rst_fee", fee, 0);
        chk("rst_gate", gate_open, 0);
        chk("rst_lock", lockout, 0);

        do_issue(5'h03);
        do_issue(5'h11);
        chk("iss_occ2", occupancy, 2);
        chk("iss_ready", issue_ready, 1);
        do_issue(5'h03);
        chk("iss_dup_occ", occupancy, 2);

        do_tick(4);
`ifdef PARK_FEE_EN
        press("match11", 5'h11, 3, 1'b1, 8'd4, 1'b1);
`else
        press("match11", 5'h11, 3, 1'b1, 8'd0, 1'b1);
`endif
        chk("m11_gate", gate_open, 1);
        chk("m11_occ", occupancy, 1);
        do_tick(2);
        chk("m11_gate_2t", gate_open, 1);
        do_tick(1);
        chk("m11_gate_3t", gate_open, 0);
        chk("m11_busy", busy, 0);

        do_issue(5'h0A);
`ifdef PARK_FEE_EN
        press("match0a", 5'h0A, 3, 1'b1, 8'd1, 1'b1);
`else
        press("match0a", 5'h0A, 3, 1'b1, 8'd0, 1'b1);
`endif
        do_tick(3);
        chk("m0a_gate_closed", gate_open, 0);

        for (int a = 0; a < 3; a++) begin
            press("wrong", 5'h1F, 9, 1'b0, 8'd0, 1'b0);
            chk("wrong_lock", lockout, (a == 2) ? 1 : 0);
            if (a < 2) step();
        end
        exit_btn = 1'b1;
        token_input = 5'h03;
        step();
        exit_btn = 1'b0;
        seen_rv = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (result_valid) seen_rv = 1'b1;
        end
        chk("lock_ignores_btn", seen_rv, 0);
        do_tick(9);
        chk("lock_9t", lockout, 1);
        do_tick(1);
        chk("lock_10t", lockout, 0);
`ifdef PARK_FEE_EN
        press("after_lock", 5'h03, 2, 1'b1, 8'd20, 1'b1);
`else
        press("after_lock", 5'h03, 2, 1'b1, 8'd0, 1'b1);
`endif
        do_tick(3);
        chk("al_occ", occupancy, 0);

        for (int t = 1; t <= 8; t++) do_issue(5'(t));
        chk("full_occ", occupancy, 8);
        chk("full_ready", issue_ready, 0);
        issue_valid = 1'b1;
        issue_token = 5'h15;
        step();
        chk("full_held", occupancy, 8);
        press("free03", 5'h03, 4, 1'b1, 8'd0, 1'b0);
        chk("free_occ", occupancy, 7);
        chk("free_ready", issue_ready, 1);
        step();
        issue_valid = 1'b0;
        chk("refill_occ", occupancy, 8);
        do_tick(3);
        press("find15", 5'h15, 4, 1'b1, 8'd0, 1'b0);
        do_tick(3);

        exit_sensor = 1'b0;
        exit_btn    = 1'b1;
        token_input = 5'h01;
        step();
        exit_btn = 1'b0;
        seen_busy = 1'b0;
        seen_rv   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (busy) seen_busy = 1'b1;
            if (result_valid) seen_rv = 1'b1;
        end
        chk("nosensor_busy", seen_busy, 0);
        chk("nosensor_rv", seen_rv, 0);

        exit_sensor = 1'b1;
        token_input = 5'h1F;
        exit_btn    = 1'b1;
        step();
        exit_btn = 1'b0;
        step(2);
        chk("scan_busy", busy, 1);
        reset = 1'b1;
        step();
        chk("midrst_occ", occupancy, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ok", result_ok, 0);
        chk("midrst_fee", fee, 0);
        chk("midrst_ready", issue_ready, 1);
        chk("midrst_gate", gate_open, 0);
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
